gate_truth_checker: RTL and testbench

//  Synthesizable self-checking driver for small combinational gates (gate_and etc.).
//  On start it walks every input vector 0..2^N_INPUTS-1 onto the DUT inputs.

---
 rtl/gate_truth_checker.sv | 153 +++++++++++++++
 tb/tb_gate_truth_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: walks every input vector onto a small combinational
// gate and compares each settled output against a latched truth table.
module gate_truth_checker #(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(1<<N_INPUTS)-1:0] truth_table,
  output logic [N_INPUTS-1:0]      vec_out,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         err_count,
  output logic [N_INPUTS-1:0]      first_fail_vec,
  output logic                     fail_seen
);

  localparam int unsigned N_VEC = 1 << N_INPUTS;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [N_INPUTS-1:0] LAST_IDX = N_INPUTS'(N_VEC - 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [N_VEC-1:0]      exp_q, exp_d;
  logic [N_INPUTS-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [N_INPUTS-1:0]   ffv_q, ffv_d;
  logic                  fail_q, fail_d;
  logic                  mismatch_c;

  // X/Z on the gate output must count as a failure, hence case inequality.
  assign mismatch_c = (dut_out !== exp_q[idx_q]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0 && idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    exp_d  = exp_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    err_d  = err_q;
    ffv_d  = ffv_q;
    fail_d = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d  = truth_table;
          err_d  = '0;
          fail_d = 1'b0;
          ffv_d  = '0;
          pass_d = 1'b0;
          idx_d  = '0;
          busy_d = 1'b1;
          cnt_d  = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (mismatch_c) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (!fail_q) begin
              ffv_d  = idx_q;
              fail_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_d == '0) && !fail_d;
          end else begin
            idx_d = idx_q + N_INPUTS'(1);
            cnt_d = CNT_LOAD;
          end
        end
      end
      ST_DONE: begin
        idx_d = '0;
      end
      default: begin
        idx_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Run registers; reset aborts a run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      ffv_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      ffv_q  <= ffv_d;
      fail_q <= fail_d;
    end
  end

  assign vec_out        = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (2-input/8-bit errors and
// 3-input/1-bit errors) driving behavioural gates, random tables and noise.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: N=2, S=2, ERR_W=8
  logic       start_a;
  logic [3:0] truth_a;
  logic [1:0] vec_a;
  logic       dut_a;
  logic       busy_a, done_a, pass_a, fail_a;
  logic [7:0] err_a;
  logic [1:0] ffv_a;
  logic [3:0] gfn_a;

  // Instance B: N=3, S=1, ERR_W=1
  logic       start_b;
  logic [7:0] truth_b;
  logic [2:0] vec_b;
  logic       dut_b;
  logic       busy_b, done_b, pass_b, fail_b;
  logic [0:0] err_b;
  logic [2:0] ffv_b;
  logic [7:0] gfn_b;

  // Gates under test modelled as lookup of their own function table.
  assign dut_a = gfn_a[vec_a];
  assign dut_b = gfn_b[vec_b];

  gate_truth_checker #(.N_INPUTS(2), .SETTLE_CYCLES(2), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .truth_table(truth_a),
    .vec_out(vec_a), .dut_out(dut_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_vec(ffv_a), .fail_seen(fail_a)
  );

  gate_truth_checker #(.N_INPUTS(3), .SETTLE_CYCLES(1), .ERR_W(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .truth_table(truth_b),
    .vec_out(vec_b), .dut_out(dut_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_vec(ffv_b), .fail_seen(fail_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, "_vec"},  32'(vec_a),  0);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_pass"}, 32'(pass_a), 0);
    chk({tag, "_err"},  32'(err_a),  0);
    chk({tag, "_ffv"},  32'(ffv_a),  0);
    chk({tag, "_fail"}, 32'(fail_a), 0);
  endtask

  // Full run on instance A with cycle-accurate checks; expectations come from
  // the mismatch mask tbl^gfn and the rule "each vector held SETTLE+1 cycles".
  task automatic run_a(input logic [3:0] tbl, input logic [3:0] gfn, input bit noise);
    int total;
    int exp_err;
    int exp_first;
    logic [3:0] mask;
    total     = 4 * 3;
    mask      = tbl ^ gfn;
    exp_err   = $countones(mask);
    exp_first = 0;
    for (int i = 3; i >= 0; i--) if (mask[i]) exp_first = i;

    @(negedge clk);
    truth_a = tbl;
    gfn_a   = gfn;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    truth_a = 4'($urandom);
    chk("a_busy_acc", 32'(busy_a), 1);
    chk("a_vec_acc",  32'(vec_a),  0);
    for (int c = 1; c <= total; c++) begin
      start_a = (noise && c < total && ($urandom_range(0, 2) == 0)) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (c < total) begin
        chk("a_run_busy", 32'(busy_a), 1);
        chk("a_run_done", 32'(done_a), 0);
        chk("a_run_vec",  32'(vec_a),  32'(c / 3));
      end else begin
        chk("a_done",      32'(done_a), 1);
        chk("a_done_busy", 32'(busy_a), 0);
        chk("a_done_vec",  32'(vec_a),  3);
        chk("a_err",       32'(err_a),  32'(exp_err));
        chk("a_fail",      32'(fail_a), 32'(exp_err != 0));
        chk("a_ffv",       32'(ffv_a),  32'(exp_first));
        chk("a_pass",      32'(pass_a), 32'(exp_err == 0));
      end
    end
    start_a = 1'b0;
    @(negedge clk);
    chk("a_post_done", 32'(done_a), 0);
    chk("a_post_busy", 32'(busy_a), 0);
    chk("a_post_vec",  32'(vec_a),  0);
    chk("a_hold_err",  32'(err_a),  32'(exp_err));
    chk("a_hold_pass", 32'(pass_a), 32'(exp_err == 0));
  endtask

  // Run on instance B checking latency and final saturated results.
  task automatic run_b(input logic [7:0] tbl, input logic [7:0] gfn);
    int cyc;
    logic [7:0] mask;
    int exp_first;
    mask      = tbl ^ gfn;
    exp_first = 0;
    for (int i = 7; i >= 0; i--) if (mask[i]) exp_first = i;
    @(negedge clk);
    truth_b = tbl;
    gfn_b   = gfn;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_latency", 32'(cyc), 16);
    chk("b_err",     32'(err_b),  32'(mask != 0));
    chk("b_fail",    32'(fail_b), 32'(mask != 0));
    chk("b_ffv",     32'(ffv_b),  32'(exp_first));
    chk("b_pass",    32'(pass_b), 32'(mask == 0));
    @(negedge clk);
    chk("b_post_done", 32'(done_b), 0);
  endtask

  initial begin
    int cyc;
    int dones;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    truth_a = '0;
    truth_b = '0;
    gfn_a   = 4'b1000;
    gfn_b   = 8'b1000_0000;
    #3;
    chk_all_zero_a("rst");
    chk("rst_b_busy", 32'(busy_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // AND gate against correct table, then OR table, then noisy start.
    run_a(4'b1000, 4'b1000, 1'b0);
    run_a(4'b1110, 4'b1000, 1'b0);
    run_a(4'b1000, 4'b1000, 1'b1);

    // Abort mid-run once vector 2 is on the bus.
    @(negedge clk);
    truth_a = 4'b1000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (vec_a != 2'd2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_idx2", 32'(vec_a), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero_a("abort");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("abort_no_done", 32'(dones), 0);
    run_a(4'b1000, 4'b1000, 1'b0);

    // Random gates and tables.
    for (int r = 0; r < 20; r++) begin
      run_a(4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Saturation on a 1-bit error counter, then random runs.
    run_b(8'b0111_1111, 8'b1000_0000);
    run_b(8'b1000_0000, 8'b1000_0000);
    for (int r = 0; r < 6; r++) begin
      run_b(8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
